// File: rtl/ret_burst_drain_if.sv
// ret_burst_drain_if: groups the return-FIFO read port and the host burst
// handshake of the drain engine. The optional abort input is present only
// when RET_DRAIN_FLUSH_EN is defined.
//
// Handshake: a burst transfers on every rising edge where out_valid and
// out_ready are both high. out_valid, once raised, stays high with out_data
// stable until that transfer (or until reset/flush). out_ready has no effect
// while out_valid is low.
interface ret_burst_drain_if #(
    parameter int WIDTH          = 16,
    parameter int BURST_LEN_LOG2 = 2
);
    logic [WIDTH-1:0]                       fifo_data_out;
    logic                                   fifo_empty;
    logic                                   fifo_get;
    logic [WIDTH*(1<<BURST_LEN_LOG2)-1:0]   out_data;
    logic                                   out_valid;
    logic                                   out_ready;
`ifdef RET_DRAIN_FLUSH_EN
    logic                                   flush;

    // Drain engine side
    modport master (
        input  fifo_data_out, fifo_empty, out_ready, flush,
        output fifo_get, out_data, out_valid
    );

    // FIFO / host side
    modport slave (
        output fifo_data_out, fifo_empty, out_ready, flush,
        input  fifo_get, out_data, out_valid
    );
`else
    // Drain engine side
    modport master (
        input  fifo_data_out, fifo_empty, out_ready,
        output fifo_get, out_data, out_valid
    );

    // FIFO / host side
    modport slave (
        output fifo_data_out, fifo_empty, out_ready,
        input  fifo_get, out_data, out_valid
    );
`endif
endinterface

// File: rtl/ret_burst_drain.sv
// ret_burst_drain: pops BURST_LEN beats from a return FIFO with one-cycle
// registered read latency, packs them (beat 0 in the low bits) and offers
// the packed word to the host over a valid/ready handshake.
// Optional feature macro: RET_DRAIN_FLUSH_EN adds the flush abort input.
// dbg_state exposes the FSM state (0 = FILL, 1 = HOLD).
module ret_burst_drain #(
    parameter int WIDTH          = 16,
    parameter int BURST_LEN_LOG2 = 2
) (
    input  logic               clk,
    input  logic               reset,
    ret_burst_drain_if.master  bus,
    output logic [0:0]         dbg_state
);
    localparam int BURST_LEN = 1 << BURST_LEN_LOG2;
    localparam int CW        = BURST_LEN_LOG2 + 1;

    localparam logic [0:0] ST_FILL = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BURST_LEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(BURST_LEN - 1);

    logic [0:0]                   state;
    logic [CW-1:0]                issued;
    logic [CW-1:0]                recvd;
    logic                         get_q;
    logic [WIDTH*BURST_LEN-1:0]   data_q;
    logic                         get;
    logic                         flush_w;

`ifdef RET_DRAIN_FLUSH_EN
    assign flush_w = bus.flush;
`else
    assign flush_w = 1'b0;
`endif

    // Pop whenever filling, data is available and the burst still needs beats;
    // issue stops at BURST_LEN so in-flight beats never exceed slot capacity.
    always_comb begin
        get = 1'b0;
        if (!reset && state == ST_FILL && !bus.fifo_empty &&
            issued < CNT_FULL && !flush_w) begin
            get = 1'b1;
        end
    end

    assign bus.fifo_get  = get;
    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_data  = data_q;
    assign dbg_state     = state;

    // Burst FSM, issue/capture counters and beat packing
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_FILL;
            issued <= '0;
            recvd  <= '0;
            get_q  <= 1'b0;
            data_q <= '0;
        end else if (flush_w) begin
            // Abort: clearing get_q drops the beat still in flight.
            state  <= ST_FILL;
            issued <= '0;
            recvd  <= '0;
            get_q  <= 1'b0;
        end else if (state == ST_HOLD) begin
            if (bus.out_ready) begin
                state  <= ST_FILL;
                issued <= '0;
                recvd  <= '0;
                get_q  <= 1'b0;
            end
        end else begin
            get_q <= get;
            if (get) begin
                issued <= issued + CNT_ONE;
            end
            if (get_q) begin
                for (int k = 0; k < BURST_LEN; k++) begin
                    if (recvd == CW'(k)) begin
                        data_q[k*WIDTH +: WIDTH] <= bus.fifo_data_out;
                    end
                end
                recvd <= recvd + CNT_ONE;
                if (recvd == CNT_LAST) begin
                    state <= ST_HOLD;
                end
            end
        end
    end
endmodule

// File: doc/ret_burst_drain.md
# ret_burst_drain

Read-side drain engine for the DDR2 controller's return FIFO. It pops single-width beats from a synchronous FIFO with one-cycle registered read latency. It packs `BURST_LEN` consecutive beats into one wide word and presents that word to the host over a valid/ready handshake. It sits between the return FIFO's `get`/`data_out`/`empty` ports and the host read-data interface.

## Interface
Clock is `clk`; reset is `reset`, synchronous, active-high.

Parameters:
- `WIDTH`, 16, beat width, equal to the return FIFO's `WIDTH`.
- `BURST_LEN_LOG2`, 2, log2 of beats per burst; `BURST_LEN = 1 << BURST_LEN_LOG2`.

Ports:
- `clk`  in  1  rising-edge clock, shared with the FIFO.
- `reset`  in  1  synchronous active-high reset.
- `fifo_data_out`  in  `WIDTH`  return FIFO registered read data.
- `fifo_empty`  in  1  return FIFO empty flag.
- `fifo_get`  out  1  pop request to the return FIFO; combinational.
- `out_data`  out  `WIDTH*BURST_LEN`  packed burst; beat 0 in bits `[WIDTH-1:0]`, beat k in bits `[(k+1)*WIDTH-1:k*WIDTH]`.
- `out_valid`  out  1  `out_data` holds a complete burst.
- `out_ready`  in  1  host accepts the burst.
- `flush`  in  1  abandon the current burst; present only with `RET_DRAIN_FLUSH_EN`.

## Operation
- States: FILL (reset state) and HOLD.
- Counters are `BURST_LEN_LOG2+1` bits wide, with no wrap inside a burst:
  - `issued` counts gets issued in the current burst.
  - `recvd` counts beats captured in the current burst.
- `get_q` is a 1-bit register that records a get issued in the previous cycle.
- `fifo_get` = !reset && state==FILL && !fifo_empty && issued < BURST_LEN (and !flush when enabled).
- Each cycle `fifo_get` is high, `issued` increments.
- Each cycle `get_q` is 1, `fifo_data_out` is written into beat slot `recvd` and `recvd` increments.
- FILL -> HOLD when the capture that brings `recvd` to `BURST_LEN` occurs. `out_valid` is high in HOLD only.
- HOLD -> FILL when `out_valid && out_ready`. On that transition, `issued`, `recvd` and `get_q` are cleared.
- In HOLD, `fifo_get` = 0 and `out_data` is stable until accepted.
- An empty FIFO mid-burst stalls issue without penalty: the partial burst is held and resumes when `fifo_empty` deasserts.
- A beat is never popped and then dropped, except under `flush`.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `fifo_get` = 0.
  - state = FILL, `issued` = `recvd` = 0, `get_q` = 0.
- Reset mid-burst discards partial beats and a held burst. `fifo_get` is low in the reset cycle.
- Read latency: a get in cycle N means the beat is captured at the end of cycle N+1.
- With the FIFO continuously non-empty, gets are issued in cycles 0..BURST_LEN-1 and `out_valid` rises in cycle BURST_LEN+1.
- `out_ready` high in the first valid cycle means the burst is accepted that edge. FILL resumes next cycle and the next get issues then.
- Sustained throughput is one burst per BURST_LEN+2 cycles.
- `out_ready` is ignored while `out_valid` = 0.

## Configuration
- `RET_DRAIN_FLUSH_EN` defined: the `flush` port exists.
  - `flush` high forces `fifo_get` = 0 in that cycle.
  - At the edge ending that cycle, the block goes to FILL, clears `issued`, `recvd` and `get_q`, and deasserts `out_valid`.
  - The beat arriving from a get issued in the flush cycle's predecessor is discarded, because `get_q` is cleared.
  - `out_data` contents are don't-care until the next burst completes.
  - Flush takes precedence over a simultaneous `out_ready` acceptance.
- `RET_DRAIN_FLUSH_EN` undefined: no `flush` port; behaviour is as if `flush` = 0.

## Test plan
- FIFO preloaded with 0x0001..0x0004, `out_ready` = 1 -> `fifo_get` high in cycles 0-3. `out_valid` is high in cycle 5 only, with `out_data` = 0x0004_0003_0002_0001.
- Preload 0xA0..0xA7, `out_ready` = 1 -> two bursts, 0x00A3_00A2_00A1_00A0 then 0x00A7_00A6_00A5_00A4. `out_valid` rises in cycles 5 and 11.
- Preload 2 beats, wait 10 cycles, push 2 more -> `out_valid` stays 0 and `fifo_get` stays 0 while empty. The burst completes 2 cycles after the last get with all four beats in order.
- Complete burst with `out_ready` = 0 for 7 cycles -> `out_valid` and `out_data` are stable, `fifo_get` = 0 throughout, and the FIFO fillcount is unchanged. Raising `out_ready` gives acceptance in one cycle.
- Assert `reset` after 2 captured beats -> next cycle `out_valid` = 0 and `out_data` = 0. After release, the next burst contains only beats popped after reset.
- With `RET_DRAIN_FLUSH_EN`: `flush` one cycle after the third get -> the third beat is discarded. The next burst starts from the fourth FIFO entry and `out_valid` is not asserted for the aborted burst.
